// File: rtl/apb_master_module.sv
// -----------------------------------------------------------------------------
// apb_master_module
//
// APB requester that drives the APB slave port of the matmul block. The host
// side hands over one command at a time on a valid/ready handshake. The block
// then runs the APB SETUP and ACCESS phases and waits out any slave wait
// states. It returns exactly one response pulse per accepted command.
//
// Optional feature (compile-time macro):
//   APB_TIMEOUT_EN  - abort an ACCESS phase that has waited TIMEOUT_CYCLES
//                     cycles without pready_i; it completes with an error.
//                     Undefined: ACCESS waits for pready_i indefinitely.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   cmd_valid_i/cmd_ready_o command handshake; accepted when both are high
//   cmd_write_i             1 = write, 0 = read
//   cmd_addr_i              target address
//   cmd_wdata_i             write data
//   cmd_strb_i              write lane strobes, one per DATA_WIDTH lane
//   rsp_valid_o             one-cycle pulse, rsp_rdata_o/rsp_err_o valid
//   rsp_rdata_o             read data (0 for writes and errors), held
//   rsp_err_o               transfer error, held
//   busy_o                  transfer in progress (SETUP or ACCESS)
//   psel_o, penable_o       APB phase control
//   pwrite_o, paddr_o       APB direction and address
//   pwdata_o, pstrb_o       APB write data and strobes (0 for reads)
//   pready_i, pslverr_i     APB slave ready / error (sampled in ACCESS only)
//   prdata_i                APB slave read data
// -----------------------------------------------------------------------------
module apb_master_module #(
    parameter int  DATA_WIDTH     = 32,
    parameter int  BUS_WIDTH      = 64,
    parameter int  ADDR_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int STRB_WIDTH     = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [STRB_WIDTH-1:0] cmd_strb_i,

    output logic                  rsp_valid_o,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,

    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   accept;
    logic                   timeout_hit;
    logic                   rsp_valid_d;
    logic                   rsp_err_d;
    logic [BUS_WIDTH-1:0]   rsp_rdata_d;

    // cmd_ready_o is registered as (state == IDLE), so the FSM state alone
    // decides whether a command is taken.
    assign accept = cmd_valid_i && (state_q == IDLE);

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Counts ACCESS cycles that ended without pready_i. The abort fires in
    // the TIMEOUT_CYCLES-th such cycle, so the transfer never spends more
    // than TIMEOUT_CYCLES cycles in ACCESS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            to_cnt_q <= '0;
        end else if (state_q == ACCESS && !pready_i) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // pready_i in the limit cycle takes priority in the FSM below.
    assign timeout_hit = (state_q == ACCESS) && !pready_i &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // FSM state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next response values.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_o;
        rsp_rdata_d = rsp_rdata_o;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                end
            end

            SETUP: begin
                state_d = ACCESS;
            end

            ACCESS: begin
                if (pready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr_i;
                    rsp_rdata_d = (!pwrite_o && !pslverr_i) ? prdata_i : '0;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered control and response outputs, all derived from the next
    // state, so they line up with the FSM state in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            cmd_ready_o <= (state_d == IDLE);
            busy_o      <= (state_d != IDLE);
            psel_o      <= (state_d != IDLE);
            penable_o   <= (state_d == ACCESS);
            rsp_valid_o <= rsp_valid_d;
            rsp_err_o   <= rsp_err_d;
            rsp_rdata_o <= rsp_rdata_d;
        end
    end

    // Command capture. The APB address/data/strobe registers load only on
    // accept, so they stay stable from SETUP through the last ACCESS cycle.
    // Reads drive zero data and zero strobes whatever the host presented.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwrite_o <= 1'b0;
            paddr_o  <= '0;
            pwdata_o <= '0;
            pstrb_o  <= '0;
        end else if (accept) begin
            pwrite_o <= cmd_write_i;
            paddr_o  <= cmd_addr_i;
            pwdata_o <= cmd_write_i ? cmd_wdata_i : '0;
            pstrb_o  <= cmd_write_i ? cmd_strb_i  : '0;
        end
    end

endmodule

// File: tb/tb_apb_master_module.sv
// -----------------------------------------------------------------------------
// tb_apb_master_module
//
// Self-checking bench for apb_master_module (default parameters). A table of
// transfers is run back-to-back against an APB slave model. The expected
// responses go into a queue when each command is driven. A monitor pops and
// compares them when rsp_valid_o pulses. Hand-written sequences cover reset
// in ACCESS and, with APB_TIMEOUT_EN, the ACCESS timeout abort.
// -----------------------------------------------------------------------------
module tb_apb_master_module;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [63:0] cmd_wdata_i;
    logic [1:0]  cmd_strb_i;
    logic        rsp_valid_o;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] paddr_o;
    logic [63:0] pwdata_o;
    logic [1:0]  pstrb_o;
    logic        pready_i;
    logic        pslverr_i;
    logic [63:0] prdata_i;

    apb_master_module dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .cmd_strb_i  (cmd_strb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .pstrb_o     (pstrb_o),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i),
        .prdata_i    (prdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [1:0]  strb;
        int          waits;
        logic        err;
        logic [63:0] prdata;
        logic [1:0]  exp_pstrb;
        logic [63:0] exp_pwdata;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
    } rsp_t;

    localparam int NVEC = 8;

    vec_t        vecs [NVEC];
    rsp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          pushed = 0;
    logic        last_err = 1'b0;
    logic [63:0] last_rdata = '0;

    // Slave model configuration for the transfer in flight.
    int          cur_wait = 0;
    logic        cur_err = 1'b0;
    logic [63:0] cur_prdata = '0;
    int          acc_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever @(posedge clk_i) cyc++;

    // APB slave model: pready_i rises in ACCESS cycle number cur_wait. Outside
    // ACCESS the slave inputs carry random junk the master must ignore.
    initial forever begin
        @(negedge clk_i);
        if (psel_o && penable_o) begin
            if (acc_cnt == cur_wait) begin
                pready_i  = 1'b1;
                pslverr_i = cur_err;
                prdata_i  = cur_prdata;
            end else begin
                pready_i  = 1'b0;
                pslverr_i = 1'($urandom_range(0, 1));
                prdata_i  = {$urandom, $urandom};
            end
            acc_cnt++;
        end else begin
            acc_cnt   = 0;
            pready_i  = 1'($urandom_range(0, 1));
            pslverr_i = 1'($urandom_range(0, 1));
            prdata_i  = {$urandom, $urandom};
        end
    end

    // Response monitor / scoreboard.
    initial forever begin
        @(negedge clk_i);
        if (rsp_valid_o === 1'b1) begin
            pulses++;
            check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_err", rsp_err_o, e.err);
                check("rsp_rdata", rsp_rdata_o, e.rdata);
            end
        end
    end

    // Drive one command starting at the current negedge (cycle N) and follow
    // it to its response. Returns at the negedge of the response cycle, so a
    // following call is accepted back-to-back in that cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int   start;
        bit   done;
        rsp_t e;
        cur_wait   = v.waits;
        cur_err    = v.err;
        cur_prdata = v.prdata;
        check($sformatf("v%0d_cmd_ready", idx), cmd_ready_o, 1'b1);
        cmd_valid_i = 1'b1;
        cmd_write_i = v.write;
        cmd_addr_i  = v.addr;
        cmd_wdata_i = v.wdata;
        cmd_strb_i  = v.strb;
        e.err   = v.exp_err;
        e.rdata = v.exp_rdata;
        exp_q.push_back(e);
        pushed++;
        start = cyc;
        @(negedge clk_i);
        // SETUP. Keep valid high with junk: it must be ignored outside IDLE.
        cmd_write_i = ~v.write;
        cmd_addr_i  = $urandom;
        cmd_wdata_i = {$urandom, $urandom};
        cmd_strb_i  = ~v.strb;
        check($sformatf("v%0d_setup_ctl", idx),
              {psel_o, penable_o, busy_o, cmd_ready_o, rsp_valid_o}, 5'b10100);
        check($sformatf("v%0d_setup_addr", idx), {pwrite_o, paddr_o}, {v.write, v.addr});
        check($sformatf("v%0d_setup_pwdata", idx), pwdata_o, v.exp_pwdata);
        check($sformatf("v%0d_setup_pstrb", idx), pstrb_o, v.exp_pstrb);
        check($sformatf("v%0d_rsp_hold", idx), {rsp_err_o, rsp_rdata_o}, {last_err, last_rdata});
        done = 1'b0;
        for (int i = 0; i < v.waits + 10 && !done; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o === 1'b1) begin
                done = 1'b1;
            end else begin
                check($sformatf("v%0d_access_hold", idx),
                      {psel_o, penable_o, busy_o, pwrite_o, paddr_o, pstrb_o},
                      {3'b111, v.write, v.addr, v.exp_pstrb});
                check($sformatf("v%0d_access_pwdata", idx), pwdata_o, v.exp_pwdata);
            end
        end
        cmd_valid_i = 1'b0;
        check($sformatf("v%0d_rsp_seen", idx), done, 1'b1);
        check($sformatf("v%0d_latency", idx), cyc - start, 3 + v.waits);
        check($sformatf("v%0d_rsp_ctl", idx),
              {psel_o, penable_o, busy_o, cmd_ready_o}, 4'b0001);
        last_err   = v.exp_err;
        last_rdata = v.exp_rdata;
    endtask

    initial begin
        //            write addr          wdata                   strb  w  err prdata                  pstrb pwdata                  err   rdata
        vecs[0] = '{1'b1, 32'h0000_0001, 64'hAAAA_5555_1234_5678, 2'b11, 0, 1'b0, 64'h1111_2222_3333_4444, 2'b11, 64'hAAAA_5555_1234_5678, 1'b0, 64'h0};
        vecs[1] = '{1'b0, 32'h0000_0001, 64'hFFFF_0000_FFFF_0000, 2'b11, 0, 1'b0, 64'hDEAD_BEEF_0000_0001, 2'b00, 64'h0, 1'b0, 64'hDEAD_BEEF_0000_0001};
        vecs[2] = '{1'b0, 32'h0000_0040, 64'h5A5A_5A5A_5A5A_5A5A, 2'b01, 3, 1'b0, 64'h0123_4567_89AB_CDEF, 2'b00, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{1'b1, 32'h0000_0080, 64'hCAFE_F00D_0BAD_BEEF, 2'b01, 0, 1'b1, 64'h7777_7777_7777_7777, 2'b01, 64'hCAFE_F00D_0BAD_BEEF, 1'b1, 64'h0};
        vecs[4] = '{1'b0, 32'h0000_0084, 64'h0, 2'b10, 1, 1'b1, 64'h9999_8888_7777_6666, 2'b00, 64'h0, 1'b1, 64'h0};
        vecs[5] = '{1'b1, 32'h0000_0100, 64'h1234_0000_0000_4321, 2'b00, 2, 1'b0, 64'hABCD_ABCD_ABCD_ABCD, 2'b00, 64'h1234_0000_0000_4321, 1'b0, 64'h0};
        vecs[6] = '{1'b0, 32'h0000_0200, 64'h0, 2'b11, 15, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7] = '{1'b1, 32'hFFFF_FFFC, 64'h8000_0000_0000_0001, 2'b10, 0, 1'b0, 64'h5555_5555_5555_5555, 2'b10, 64'h8000_0000_0000_0001, 1'b0, 64'h0};

        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        cmd_strb_i  = '0;
        repeat (2) @(negedge clk_i);
        check("reset_ctl", {cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o, psel_o, penable_o, pwrite_o}, 7'b1000000);
        check("reset_data", {paddr_o, pstrb_o, rsp_rdata_o}, '0);
        check("reset_pwdata", pwdata_o, 64'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Table: consecutive calls are accepted back-to-back in the rsp cycle.
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end
        @(negedge clk_i);
        check("idle_no_pulse", rsp_valid_o, 1'b0);

        // Reset asserted in ACCESS: APB controls drop at once, no response.
        cur_wait    = 1000;
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 32'h0000_0300;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check("rst_pre_access", {psel_o, penable_o}, 2'b11);
        #2 rst_i = 1'b1;
        #1;
        check("rst_async_drop", {psel_o, penable_o, busy_o, cmd_ready_o}, 4'b0001);
        @(negedge clk_i);
        rst_i      = 1'b0;
        last_err   = 1'b0;
        last_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("rst_no_rsp", {rsp_valid_o, cmd_ready_o, psel_o}, 3'b010);
        end
        run_vec(vecs[1], 100);

`ifdef APB_TIMEOUT_EN
        // pready_i never rises: abort after 16 ACCESS cycles with an error.
        begin
            int   start;
            int   acc;
            bit   done;
            rsp_t e;
            cur_wait    = 1000;
            cmd_valid_i = 1'b1;
            cmd_write_i = 1'b1;
            cmd_addr_i  = 32'h0000_0400;
            cmd_wdata_i = 64'h0F0F_0F0F_0F0F_0F0F;
            cmd_strb_i  = 2'b11;
            e.err   = 1'b1;
            e.rdata = '0;
            exp_q.push_back(e);
            pushed++;
            start = cyc;
            acc   = 0;
            done  = 1'b0;
            @(negedge clk_i);
            cmd_valid_i = 1'b0;
            for (int i = 0; i < 64 && !done; i++) begin
                @(negedge clk_i);
                if (rsp_valid_o === 1'b1) done = 1'b1;
                else if (psel_o && penable_o) acc++;
            end
            check("to_rsp_seen", done, 1'b1);
            check("to_access_cycles", acc, 16);
            check("to_latency", cyc - start, 18);
            check("to_ctl", {psel_o, penable_o, cmd_ready_o}, 3'b001);
        end
`endif

        repeat (3) @(negedge clk_i);
        check("queue_empty", exp_q.size(), 0);
        check("pulse_count", pulses, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
